getir_kuyruklu: RTL
===================

// Module: getir_kuyruklu
// PURPOSE
//  Parametrised fetch stage; next generation of getir. Issues PCs to the L1 instruction memory
//  and buffers returned words in a KUYRUK_DERINLIK-deep prefetch queue, so L1 wait cycles are
//  hidden from the decode stage. Feeds the cyo_* decode register; takes redirects from execute
//  and stall/flush from the hazard unit (ddb).
// PARAMETERS
//  ADR_W           18     top address bit; all PCs are [ADR_W:1] (halfword units, +2 = 4 bytes)
//  KUYRUK_DERINLIK 4      prefetch queue entries; power of two, >= 2
//  BASLANGIC_PS    'h0    PC after reset, [ADR_W:1] units
// PORTS
//  clk_i                    in  1        clock
//  rst_i                    in  1        reset, asynchronous, active-high
//  l1b_bekle_i              in  1        1 = L1 has no data for l1b_adr_o this cycle
//  l1b_deger_i              in  32       instruction word for l1b_adr_o, valid when bekle=0
//  l1b_adr_o                out  ADR_W   fetch address
//  yrt_atlanan_ps_gecerli_i in  1        redirect strobe from execute
//  yrt_atlanan_ps_i         in  ADR_W    redirect target
//  ddb_durdur_i             in  1        hold decode register
//  ddb_bosalt_i             in  1        load bubble into decode register
//  ddb_hazir_o              out 1        queue non-empty
//  ddb_yanlis_tahmin_o      out 1        one-cycle pulse, cycle after a redirect
//  cyo_buyruk_o             out 32       decode instruction
//  cyo_ps_o                 out ADR_W    its PC
//  cyo_ps_artmis_o          out ADR_W    cyo_ps_o + 2 (mod 2^ADR_W)
//  cyo_gecerli_o            out 1        decode register holds a real instruction
// BEHAVIOUR
//  - Reset: fetch PC=BASLANGIC_PS, queue empty, cyo_buyruk_o=32'h0000_0013 (NOP), cyo_ps_o=0,
//    cyo_ps_artmis_o=2, cyo_gecerli_o=0, ddb_hazir_o=0, ddb_yanlis_tahmin_o=0. Reset mid-fetch
//    discards everything; first address after release is BASLANGIC_PS.
//  - l1b_adr_o = fetch PC register; held stable while l1b_bekle_i=1 or queue full.
//  - Accept: bekle=0 and queue not full and no redirect -> push {l1b_deger_i, PC}; PC += 2 (wraps).
//    bekle=0 with queue full -> word dropped, PC held (same address re-requested).
//  - Decode register loads when !ddb_durdur_i: pop head if queue non-empty, else NOP, gecerli=0.
//  - ddb_bosalt_i: decode register <= NOP, gecerli=0; queue untouched, no pop. Priority over durdur.
//  - Redirect (highest priority): queue flushed, decode register <= NOP/gecerli=0, PC <= target,
//    L1 response in that cycle discarded; ddb_yanlis_tahmin_o=1 next cycle only.
//  - Queue: simultaneous push+pop allowed when not full (count unchanged); push blocked when full
//    even if popping. Count width clog2(DEPTH)+1; pointers wrap modulo DEPTH.
//  - Latency: word accepted in cycle N (queue empty, no stall) -> visible on cyo_* in cycle N+2.
//    Sustained throughput 1 instr/cycle with bekle=0, no stall.
// CONFIGURATION
//  GETIR_BASARIM_SAYAC_EN defined: adds sayac_buyruk_o[31:0] (+1 per decode load with gecerli=1)
//  and sayac_bekleme_o[31:0] (+1 per cycle l1b_bekle_i=1); both wrap, reset to 0, unaffected by
//  redirect. Undefined: ports and counters absent; other behaviour identical.
// STRUCTURE
//  - tanimlamalar.vh: NOP encoding `NOP_BUYRUK, queue entry width macro (32+ADR_W).
//  - Sub-module getir_kuyrugu: parametrised FIFO (WIDTH, DEPTH) with push/pop/flush,
//    full/empty/count; rest (PC, decode register, redirect, counters) in getir_kuyruklu.
// TESTING
//  - Reset, bekle=0, no stall -> l1b_adr_o 0,2,4,..; cyo_ps_o=0 at cycle 2, then +2/cycle, gecerli=1.
//  - durdur=1 for 10 cycles, DEPTH=4 -> queue fills, l1b_adr_o frozen, no word lost; on release
//    PCs on cyo_ps_o strictly consecutive.
//  - Redirect to 'h100 while queue holds 3 entries -> next cycle gecerli=0, yanlis_tahmin=1,
//    l1b_adr_o='h100; next valid cyo_ps_o='h100.
//  - bosalt=1 with durdur=1 -> decode register NOP/gecerli=0, queue count unchanged.
//  - PC='h3FFFE, ADR_W=18 -> next fetch address 0, cyo_ps_artmis_o of 'h3FFFE is 0.
//  - Random bekle 50%, with SAYAC_EN -> sayac_bekleme_o equals bekle cycles, sayac_buyruk_o
//    equals valid decode loads; async reset mid-burst clears all outputs immediately.

Source files
------------

// File: rtl/getir_kuyruklu_pkg.sv
// Shared constants for the getir_kuyruklu fetch stage: NOP encoding and prefetch queue entry width.
package getir_kuyruklu_pkg;

    localparam logic [31:0] NOP_BUYRUK = 32'h0000_0013;

    // One queue entry carries the instruction word above its PC.
    function automatic int kuyruk_genislik(input int adr_w);
        return 32 + adr_w;
    endfunction

endpackage

// File: rtl/getir_kuyrugu.sv
// Parametrised prefetch FIFO for the fetch stage: push/pop/flush with full, empty and count.
module getir_kuyrugu #(
    parameter int WIDTH = 50,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    input  logic [WIDTH-1:0]         veri_i,
    output logic [WIDTH-1:0]         veri_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      count;
    logic             push_ok;
    logic             pop_ok;

    assign full_o  = (count == (PW+1)'(DEPTH));
    assign empty_o = (count == '0);
    assign count_o = count;
    assign veri_o  = mem[rd_ptr];

    // A full queue refuses pushes even when a pop happens in the same cycle.
    assign push_ok = push_i && !full_o && !flush_i;
    assign pop_ok  = pop_i && !empty_o && !flush_i;

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem[wr_ptr] <= veri_i;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/getir_kuyruklu.sv
// Fetch stage with prefetch queue feeding the cyo_* decode register.
// Optional performance counters are enabled by defining GETIR_BASARIM_SAYAC_EN.
module getir_kuyruklu
    import getir_kuyruklu_pkg::*;
#(
    parameter int               ADR_W           = 18,
    parameter int               KUYRUK_DERINLIK = 4,
    parameter logic [ADR_W:1]   BASLANGIC_PS    = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             l1b_bekle_i,
    input  logic [31:0]      l1b_deger_i,
    output logic [ADR_W:1]   l1b_adr_o,
    input  logic             yrt_atlanan_ps_gecerli_i,
    input  logic [ADR_W:1]   yrt_atlanan_ps_i,
    input  logic             ddb_durdur_i,
    input  logic             ddb_bosalt_i,
    output logic             ddb_hazir_o,
    output logic             ddb_yanlis_tahmin_o,
    output logic [31:0]      cyo_buyruk_o,
    output logic [ADR_W:1]   cyo_ps_o,
    output logic [ADR_W:1]   cyo_ps_artmis_o,
    output logic             cyo_gecerli_o
`ifdef GETIR_BASARIM_SAYAC_EN
    ,
    output logic [31:0]      sayac_buyruk_o,
    output logic [31:0]      sayac_bekleme_o
`endif
);

    localparam int GEN = kuyruk_genislik(ADR_W);
    localparam int CW  = $clog2(KUYRUK_DERINLIK) + 1;

    logic [ADR_W:1]  ps_q;
    logic            kabul;
    logic            cek;
    logic            dolu;
    logic            bos;
    logic [CW-1:0]   sayi;
    logic [GEN-1:0]  kuyruk_giris;
    logic [GEN-1:0]  kuyruk_cikis;
    logic [31:0]     bas_buyruk;
    logic [ADR_W:1]  bas_ps;

    // A redirect wins over everything: the L1 word of that cycle is dropped and nothing is popped.
    assign kabul        = !l1b_bekle_i && !dolu && !yrt_atlanan_ps_gecerli_i;
    assign cek          = !ddb_durdur_i && !ddb_bosalt_i && !yrt_atlanan_ps_gecerli_i && !bos;
    assign kuyruk_giris = {l1b_deger_i, ps_q};
    assign {bas_buyruk, bas_ps} = kuyruk_cikis;

    getir_kuyrugu #(
        .WIDTH (GEN),
        .DEPTH (KUYRUK_DERINLIK)
    ) u_kuyruk (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (kabul),
        .pop_i   (cek),
        .flush_i (yrt_atlanan_ps_gecerli_i),
        .veri_i  (kuyruk_giris),
        .veri_o  (kuyruk_cikis),
        .full_o  (dolu),
        .empty_o (bos),
        .count_o (sayi)
    );

    assign l1b_adr_o       = ps_q;
    assign ddb_hazir_o     = (sayi != '0);
    assign cyo_ps_artmis_o = cyo_ps_o + ADR_W'(2);

    // The fetch PC only advances on an accepted word, so a dropped word is re-requested.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ps_q <= BASLANGIC_PS;
        end else if (yrt_atlanan_ps_gecerli_i) begin
            ps_q <= yrt_atlanan_ps_i;
        end else if (kabul) begin
            ps_q <= ps_q + ADR_W'(2);
        end
    end

    // Decode register: bubble on redirect or flush, hold on stall, otherwise pop or insert a NOP.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cyo_buyruk_o  <= NOP_BUYRUK;
            cyo_ps_o      <= '0;
            cyo_gecerli_o <= 1'b0;
        end else if (yrt_atlanan_ps_gecerli_i || ddb_bosalt_i) begin
            cyo_buyruk_o  <= NOP_BUYRUK;
            cyo_gecerli_o <= 1'b0;
        end else if (!ddb_durdur_i) begin
            if (!bos) begin
                cyo_buyruk_o  <= bas_buyruk;
                cyo_ps_o      <= bas_ps;
                cyo_gecerli_o <= 1'b1;
            end else begin
                cyo_buyruk_o  <= NOP_BUYRUK;
                cyo_gecerli_o <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ddb_yanlis_tahmin_o <= 1'b0;
        end else begin
            ddb_yanlis_tahmin_o <= yrt_atlanan_ps_gecerli_i;
        end
    end

`ifdef GETIR_BASARIM_SAYAC_EN
    // Counters keep running across redirects; only reset clears them.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sayac_buyruk_o  <= '0;
            sayac_bekleme_o <= '0;
        end else begin
            if (cek) begin
                sayac_buyruk_o <= sayac_buyruk_o + 32'd1;
            end
            if (l1b_bekle_i) begin
                sayac_bekleme_o <= sayac_bekleme_o + 32'd1;
            end
        end
    end
`endif

endmodule
